// File: rtl/jtriders_objdma.sv
// Object-RAM DMA sequencer: copies 2**AW words from the shared source RAM into
// the object shadow buffer at vblank start. Option macro: JTRIDERS_OBJDMA_AUTO_EN.
module jtriders_objdma #(
  parameter int             AW       = 10,
  parameter logic [AW+2:0]  SRC_BASE = '0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cen,
  input  logic           lvbl,
  input  logic           dma_req,
  input  logic           cpu_cs,
  output logic [12:0]    src_addr,
  input  logic [15:0]    src_dout,
  output logic [AW-1:0]  dst_addr,
  output logic [15:0]    dst_din,
  output logic           dst_we,
  output logic           dma_bsy
);

  typedef enum logic [1:0] {IDLE, COPY, DONE} state_t;

  localparam logic [12:0]   BASE13 = 13'(SRC_BASE);
  localparam logic [AW-1:0] LAST   = '1;
`ifdef JTRIDERS_OBJDMA_AUTO_EN
  localparam logic          AUTO   = 1'b1;
`else
  localparam logic          AUTO   = 1'b0;
`endif

  state_t        state_q;
  logic          lvbl_q;
  logic          armed_q;
  logic          pending_q;
  logic          rd_vld_q;
  logic [AW:0]   cnt_q;
  logic [AW-1:0] rd_cnt_q;

  logic vb_start;
  logic arm_now;

  assign vb_start = lvbl_q & ~lvbl;
  assign arm_now  = armed_q | AUTO;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      lvbl_q    <= 1'b1;
      armed_q   <= 1'b0;
      pending_q <= 1'b0;
      rd_vld_q  <= 1'b0;
      cnt_q     <= '0;
      rd_cnt_q  <= '0;
      src_addr  <= BASE13;
      dst_addr  <= '0;
      dst_din   <= '0;
      dst_we    <= 1'b0;
      dma_bsy   <= 1'b0;
    end else begin
      lvbl_q <= lvbl;
      dst_we <= 1'b0;
      case (state_q)
        IDLE: begin
          rd_vld_q <= 1'b0;
          // A request arriving with the starting vblank is absorbed by that copy
          if (vb_start && arm_now) begin
            state_q <= COPY;
            armed_q <= 1'b0;
            cnt_q   <= '0;
            dma_bsy <= 1'b1;
          end else if (dma_req) begin
            armed_q <= 1'b1;
          end
        end
        COPY: begin
          if (dma_req) pending_q <= 1'b1;
          if (rd_vld_q) begin
            dst_we   <= 1'b1;
            dst_din  <= src_dout;
            dst_addr <= rd_cnt_q;
            if (rd_cnt_q == LAST) state_q <= DONE;
          end
          // The CPU owns the RAM whenever cpu_cs is high; the read simply waits
          if (cen && !cpu_cs && !cnt_q[AW]) begin
            src_addr <= BASE13 + 13'(cnt_q);
            rd_cnt_q <= cnt_q[AW-1:0];
            cnt_q    <= cnt_q + 1'b1;
            rd_vld_q <= 1'b1;
          end else begin
            rd_vld_q <= 1'b0;
          end
        end
        DONE: begin
          state_q   <= IDLE;
          dma_bsy   <= 1'b0;
          rd_vld_q  <= 1'b0;
          armed_q   <= pending_q | dma_req;
          pending_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtriders_objdma.sv
// Randomized self-checking bench for jtriders_objdma with a per-cycle reference
// model of request/vblank arming and the stalled word-by-word copy.
module tb_jtriders_objdma;
  localparam int          AW   = 4;
  localparam int          N    = 16;
  localparam logic [6:0]  BASE = 7'h10;
`ifdef JTRIDERS_OBJDMA_AUTO_EN
  localparam bit          AUTO = 1'b1;
`else
  localparam bit          AUTO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cen, lvbl, dma_req, cpu_cs;
  logic [12:0]   src_addr;
  logic [15:0]   src_dout;
  logic [AW-1:0] dst_addr;
  logic [15:0]   dst_din;
  logic          dst_we, dma_bsy;

  logic [15:0] mem [0:8191];
  assign src_dout = mem[src_addr];

  jtriders_objdma #(.AW(AW), .SRC_BASE(BASE)) dut (
    .clk(clk), .rst(rst), .cen(cen), .lvbl(lvbl), .dma_req(dma_req),
    .cpu_cs(cpu_cs), .src_addr(src_addr), .src_dout(src_dout),
    .dst_addr(dst_addr), .dst_din(dst_din), .dst_we(dst_we), .dma_bsy(dma_bsy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Stimulus generator for cen and cpu_cs
  int cen_mode = 0;
  bit cs_force = 0, cs_rand = 0;
  int cyc = 0;
  always @(negedge clk) begin
    #1;
    cyc++;
    case (cen_mode)
      0:       cen = 1'b1;
      1:       cen = (cyc % 4 == 0);
      default: cen = 1'($urandom_range(0, 1));
    endcase
    cpu_cs = cs_force || (cs_rand && ($urandom_range(0, 3) == 0));
  end

  // Reference model: phase 0 idle, 1 copying, 2 done
  int          m_ph, m_cnt, m_rdk;
  bit          m_armed, m_pend, m_rdv, m_lv;
  bit          e_we, e_bsy;
  logic [12:0] e_src;
  int          e_addr;
  logic [15:0] e_din;

  task automatic m_reset();
    m_ph = 0; m_cnt = 0; m_rdk = 0;
    m_armed = 0; m_pend = 0; m_rdv = 0; m_lv = 1;
    e_we = 0; e_bsy = 0; e_src = 13'(BASE); e_addr = 0; e_din = 16'h0;
  endtask

  always @(posedge clk) begin
    bit vb;
    if (rst) begin
      m_reset();
    end else begin
      vb   = m_lv && !lvbl;
      m_lv = lvbl;
      e_we = 0;
      case (m_ph)
        0: begin
          if (vb && (m_armed || AUTO)) begin
            m_ph = 1; m_armed = 0; m_cnt = 0; m_rdv = 0;
          end else if (dma_req) m_armed = 1;
        end
        1: begin
          if (dma_req) m_pend = 1;
          if (m_rdv) begin
            e_we = 1; e_addr = m_rdk; e_din = mem[e_src];
            if (m_rdk == N - 1) m_ph = 2;
          end
          if (cen && !cpu_cs && m_cnt < N) begin
            m_rdk = m_cnt; m_cnt++;
            e_src = 13'((int'(BASE) + m_rdk) % 8192);
            m_rdv = 1;
          end else m_rdv = 0;
        end
        default: begin
          m_ph = 0;
          if (dma_req) m_pend = 1;
          m_armed = m_pend; m_pend = 0;
        end
      endcase
      e_bsy = (m_ph != 0);
    end
  end

  // Per-cycle compare and run statistics
  bit          run = 0;
  int          bsy_run = 0, last_len = 0, we_cnt = 0;
  logic [15:0] first_din, last_din;
  int          first_addr, last_addr;
  always @(posedge clk) begin
    #1;
    if (run) begin
      check("dst_we", 32'(dst_we), 32'(e_we));
      check("dma_bsy", 32'(dma_bsy), 32'(e_bsy));
      check("src_addr", 32'(src_addr), 32'(e_src));
      if (e_we) begin
        check("dst_addr", 32'(dst_addr), 32'(e_addr));
        check("dst_din", 32'(dst_din), 32'(e_din));
      end
      if (dst_we) begin
        if (we_cnt == 0) begin first_din = dst_din; first_addr = int'(dst_addr); end
        last_din = dst_din; last_addr = int'(dst_addr);
        we_cnt++;
        $display("wr t=%0t addr=%0d din=%h", $time, dst_addr, dst_din);
      end
      if (dma_bsy) bsy_run++;
      else if (bsy_run > 0) begin last_len = bsy_run; bsy_run = 0; end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_req();
    dma_req = 1'b1; step(); dma_req = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int k = 0;
    while (dma_bsy && k < max) begin step(); k++; end
    total++;
    if (dma_bsy) begin
      bad++;
      $display("FAIL wait_idle act=busy exp=idle t=%0t", $time);
    end
    step(2);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    m_reset();
    #1;
    check("rst_we", 32'(dst_we), 32'd0);
    check("rst_bsy", 32'(dma_bsy), 32'd0);
    check("rst_src", 32'(src_addr), 32'(BASE));
    check("rst_daddr", 32'(dst_addr), 32'd0);
    check("rst_din", 32'(dst_din), 32'd0);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;
  endtask

  // Drop lvbl, let the copy (if any) run to completion, then raise lvbl again
  task automatic vblank(input int max);
    lvbl = 1'b0; step(3);
    wait_idle(max);
    lvbl = 1'b1; step(3);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    for (int a = 0; a < 8192; a++) mem[a] = 16'(16'hA000 + a - int'(BASE));
    cen = 1'b1; lvbl = 1'b1; dma_req = 1'b0; cpu_cs = 1'b0;
    m_reset();
    step(2);
    do_reset();
    run = 1;
    step(2);

    // No request pending
    we_cnt = 0;
    vblank(100);
    check("noreq_writes", 32'(we_cnt), AUTO ? 32'd16 : 32'd0);

    // Basic copy
    pulse_req(); step(3);
    we_cnt = 0;
    vblank(100);
    check("basic_writes", 32'(we_cnt), 32'd16);
    check("basic_bsy_len", 32'(last_len), 32'd18);
    check("basic_first_din", 32'(first_din), 32'hA000);
    check("basic_first_addr", 32'(first_addr), 32'd0);
    check("basic_last_din", 32'(last_din), 32'hA00F);
    check("basic_last_addr", 32'(last_addr), 32'd15);

    // CPU contention for 3 cen cycles with five words already read
    pulse_req(); step(3);
    we_cnt = 0;
    lvbl = 1'b0; step(); step(5);
    cs_force = 1; step(3); cs_force = 0;
    wait_idle(100);
    lvbl = 1'b1; step(3);
    check("stall_writes", 32'(we_cnt), 32'd16);
    check("stall_bsy_len", 32'(last_len), 32'd21);

    // cen every 4th clk
    cen_mode = 1;
    pulse_req(); step(3);
    we_cnt = 0;
    vblank(300);
    check("cen4_writes", 32'(we_cnt), 32'd16);
    check("cen4_bsy_range", 32'(last_len >= 60 && last_len <= 72), 32'd1);
    cen_mode = 0;

    // Request at word 7 is deferred to the next vblank
    pulse_req(); step(3);
    we_cnt = 0;
    lvbl = 1'b0; step(); step(7);
    pulse_req();
    wait_idle(100);
    lvbl = 1'b1; step(3);
    check("mid_req_writes", 32'(we_cnt), 32'd16);
    we_cnt = 0;
    vblank(100);
    check("deferred_writes", 32'(we_cnt), 32'd16);

    // Reset mid-copy at word 9
    pulse_req(); step(3);
    lvbl = 1'b0; step(); step(9);
    do_reset();
    step(3);
    lvbl = 1'b1; step(3);
    we_cnt = 0;
    vblank(100);
    check("post_rst_writes", 32'(we_cnt), AUTO ? 32'd16 : 32'd0);
    pulse_req(); step(2);
    we_cnt = 0;
    vblank(100);
    check("post_rst_req_writes", 32'(we_cnt), 32'd16);

    // Randomized frames with contention, random cen and random requests
    for (int a = 0; a < 8192; a++) mem[a] = 16'($urandom);
    cen_mode = 2; cs_rand = 1;
    for (int f = 0; f < 40; f++) begin
      int hi, lo;
      hi = $urandom_range(20, 60);
      lo = $urandom_range(5, 40);
      for (int i = 0; i < hi; i++) begin
        dma_req = ($urandom_range(0, 7) == 0);
        step();
      end
      lvbl = 1'b0;
      for (int i = 0; i < lo; i++) begin
        dma_req = ($urandom_range(0, 7) == 0);
        step();
      end
      lvbl = 1'b1;
    end
    dma_req = 1'b0; cs_rand = 0; cen_mode = 0;
    wait_idle(400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
